serializer: RTL and testbench
=============================

# serializer

Parallel-to-serial converter: accepts a `DATA_W`-bit word with a bit-count modifier and shifts out the selected bits MSB-first, one bit per clock, each with a valid strobe. It is the transmit-side counterpart of the team's deserializer. It sits between a word-oriented producer and the serial link, and its serial stream feeds the deserializer's `data_i`/`data_val_i` pair directly.

## Interface
- `DATA_W`, default 16: parallel word width; must be a power of two, at least 4.
- `MOD_W`, default `$clog2(DATA_W)`: width of the bit-count modifier.
- `clk_i` input, 1 bit: clock; all logic on the rising edge.
- `arst_n_i` input, 1 bit: reset, asynchronous, active-low; no other reset exists.
- `data_i` input, `DATA_W` bits: parallel word; the bit at `DATA_W-1` is sent first.
- `data_mod_i` input, `MOD_W` bits: number of bits to send.
  - 0 means all `DATA_W` bits.
  - 1 and 2 are illegal; the word is dropped.
  - 3..`DATA_W-1` means send that many bits, taken from the top of `data_i`.
- `data_val_i` input, 1 bit: `data_i` and `data_mod_i` are valid this cycle.
- `ser_data_o` output, 1 bit: serial data bit.
- `ser_data_val_o` output, 1 bit: `ser_data_o` is valid this cycle.
- `busy_o` output, 1 bit: high means the block cannot accept a word this cycle.

## Operation
- States: IDLE and SHIFT.
- Accept rule: a word is accepted when `data_val_i && !busy_o` and `data_mod_i` is not 1 or 2.
  - `data_val_i` while `busy_o` is high is ignored; there is no queueing.
  - An illegal mod drops the word silently, leaves the state unchanged and produces no output.
- Bit count: len = `DATA_W` if `data_mod_i` is 0, otherwise `data_mod_i`. Compute it with `MOD_W+1` bits so that `DATA_W` is representable.
- On accept:
  - Load a shift register with `data_i`.
  - Load a down-counter with len.
  - Enter SHIFT.
- In SHIFT, each cycle:
  - `ser_data_o` = shift register MSB, and `ser_data_val_o` = 1.
  - Shift the register left by one, filling with 0.
  - Decrement the counter.
- Last bit (counter = 1):
  - If a new legal word is accepted in the same cycle, reload and stay in SHIFT, giving a gapless stream.
  - Otherwise return to IDLE.
- In IDLE: `ser_data_val_o` = 0 and `ser_data_o` = 0.
- Bits below the selected count are never transmitted.
- Reset values, applied immediately on `arst_n_i` low, including mid-word:
  - state IDLE; shift register 0; counter 0.
  - `ser_data_o` 0, `ser_data_val_o` 0, `busy_o` 0.
  - A partially sent word is discarded; after release, the block waits for a fresh word.

## Timing
- All outputs are registered.
- A word accepted in cycle N produces its first bit (`data_i[DATA_W-1]`) with `ser_data_val_o` = 1 in cycle N+1, and its last bit in cycle N+len.
- `busy_o` behaviour:
  - High in cycles N+1..N+len-1.
  - Low in cycle N+len, the last-bit cycle, so the producer can present the next word there.
  - Low in IDLE.
- Back-to-back: a word accepted in cycle N+len has its first bit in cycle N+len+1, with no gap in `ser_data_val_o`.
- A word accepted while IDLE with `busy_o` = 0 has one cycle of latency to its first bit.
- Throughput: one bit per clock.
- `ser_data_o` is 0 whenever `ser_data_val_o` = 0.

## Test plan
- Reset, then `data_i`=16'hA5C3, mod=0, one-cycle `data_val_i` → 16 valid bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 in cycles N+1..N+16. `busy_o` high N+1..N+15, low at N+16; no valid bit at N+17.
- `data_i`=16'hF000, mod=3 → exactly 3 valid bits 1,1,1, then IDLE. Repeat with mod=15 → 15 bits, and bit 0 is never sent.
- mod=1 and mod=2 with `data_val_i` → `ser_data_val_o` and `busy_o` stay 0 and there is no state change. A following legal word is sent normally.
- Two words back-to-back, 16'hFFFF then 16'h0000 with mod=0, the second presented in the first word's last-bit cycle → 32 consecutive valid cycles: 16 ones then 16 zeros.
- `data_val_i` asserted with 16'h1234 while `busy_o`=1 → ignored; only the in-flight word appears on the output.
- Assert `arst_n_i` low asynchronously mid-word (between clock edges, after 5 bits) → all outputs 0 before the next edge. After release, the next word is sent in full from its MSB.
- Bench-wide checks:
  - Loop the output into the deserializer with mod=0, random words → each received word equals the sent word.
  - Reset values are checked at every reset.

Source files
------------

// File: rtl/serializer.sv
// serializer: parallel-to-serial converter, MSB first, one bit per clock.
//
// Accepts a DATA_W-bit word plus a bit-count modifier and shifts the selected
// top bits out on ser_data_o, each qualified by ser_data_val_o. The producer
// may present the next word in the last-bit cycle for a gapless stream.
//
// Ports:
//   clk_i          - clock, rising edge
//   arst_n_i       - asynchronous active-low reset
//   data_i         - parallel word, bit DATA_W-1 sent first
//   data_mod_i     - bit count: 0 = DATA_W, 1/2 illegal (dropped), else count
//   data_val_i     - data_i/data_mod_i valid this cycle
//   ser_data_o     - serial data bit (0 when not valid)
//   ser_data_val_o - serial bit valid
//   busy_o         - cannot accept a word this cycle
module serializer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  localparam logic [MOD_W:0] FullLen = (MOD_W+1)'(DATA_W);
  localparam logic [MOD_W:0] CntOne  = (MOD_W+1)'(1);
  localparam logic [MOD_W:0] CntTwo  = (MOD_W+1)'(2);

  state_e            state_q, state_d;
  // sr_q holds the bits still to be sent after the one currently on ser_data_o.
  logic [DATA_W-1:0] sr_q, sr_d;
  // cnt_q counts remaining bits including the one currently on ser_data_o.
  logic [MOD_W:0]    cnt_q, cnt_d;
  logic              ser_d, val_d, busy_d;

  logic              legal;
  logic              accept;
  logic              last_bit;
  logic [MOD_W:0]    len;

  assign legal    = (data_mod_i != MOD_W'(1)) && (data_mod_i != MOD_W'(2));
  assign accept   = data_val_i && !busy_o && legal;
  assign last_bit = (cnt_q == CntOne);
  assign len      = (data_mod_i == '0) ? FullLen : {1'b0, data_mod_i};

  // State register
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StShift;
      StShift: if (last_bit && !accept) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    sr_d   = '0;
    cnt_d  = '0;
    ser_d  = 1'b0;
    val_d  = 1'b0;
    busy_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          ser_d  = data_i[DATA_W-1];
          sr_d   = {data_i[DATA_W-2:0], 1'b0};
          cnt_d  = len;
          val_d  = 1'b1;
          busy_d = (len > CntOne);
        end
      end
      StShift: begin
        if (last_bit) begin
          // Reload on the last-bit cycle keeps the stream gapless.
          if (accept) begin
            ser_d  = data_i[DATA_W-1];
            sr_d   = {data_i[DATA_W-2:0], 1'b0};
            cnt_d  = len;
            val_d  = 1'b1;
            busy_d = (len > CntOne);
          end
        end else begin
          ser_d  = sr_q[DATA_W-1];
          sr_d   = {sr_q[DATA_W-2:0], 1'b0};
          cnt_d  = cnt_q - CntOne;
          val_d  = 1'b1;
          // Busy drops in the cycle that shows the last bit.
          busy_d = (cnt_q > CntTwo);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sr_q           <= '0;
      cnt_q          <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      sr_q           <= sr_d;
      cnt_q          <= cnt_d;
      ser_data_o     <= ser_d;
      ser_data_val_o <= val_d;
      busy_o         <= busy_d;
    end
  end

endmodule

// File: tb/tb_serializer.sv
// tb_serializer: directed self-checking bench for serializer (DATA_W = 16).
module tb_serializer;

  logic        clk;
  logic        arst_n;
  logic [15:0] data;
  logic [3:0]  data_mod;
  logic        data_val;
  logic        ser_data;
  logic        ser_data_val;
  logic        busy;

  int total = 0;
  int bad   = 0;

  serializer #(.DATA_W(16)) dut (
    .clk_i          (clk),
    .arst_n_i       (arst_n),
    .data_i         (data),
    .data_mod_i     (data_mod),
    .data_val_i     (data_val),
    .ser_data_o     (ser_data),
    .ser_data_val_o (ser_data_val),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_val"}, ser_data_val, 1'b0);
    chk1({tag, "_ser"}, ser_data, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask

  // Present one word for a single cycle, then check every bit, busy, and the
  // return to idle afterwards.
  task automatic send_check(input string tag, input logic [15:0] w, input logic [3:0] m,
                            input int len);
    data = w; data_mod = m; data_val = 1'b1;
    tick();
    data_val = 1'b0;
    for (int i = 0; i < len; i++) begin
      chk1({tag, "_val"}, ser_data_val, 1'b1);
      chk1({tag, "_bit"}, ser_data, w[15-i]);
      chk1({tag, "_busy"}, busy, (i < len - 1));
      tick();
    end
    chk_idle({tag, "_end"});
  endtask

  logic [15:0] rx;
  logic [15:0] word;
  int          nbits;

  initial begin
    arst_n = 1'b0; data = '0; data_mod = '0; data_val = 1'b0;
    #12;
    chk_idle("rst0");
    tick();
    arst_n = 1'b1;
    tick();
    chk_idle("post_rst");

    // Full word, mod 0: A5C3 -> 1010_0101_1100_0011
    send_check("a5c3", 16'hA5C3, 4'd0, 16);

    // Short counts; bit 0 set on the mod-15 word must never appear.
    send_check("m3", 16'hF000, 4'd3, 3);
    send_check("m15", 16'hF001, 4'd15, 15);

    // Illegal mods are dropped.
    data = 16'hFFFF; data_mod = 4'd1; data_val = 1'b1;
    tick();
    chk_idle("mod1");
    data_mod = 4'd2;
    tick();
    chk_idle("mod2");
    data_val = 1'b0;
    tick();
    chk_idle("mod2b");
    send_check("after_ill", 16'h8001, 4'd4, 4);

    // Back-to-back FFFF then 0000, second presented in last-bit cycle.
    data = 16'hFFFF; data_mod = 4'd0; data_val = 1'b1;
    tick();
    data_val = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk1("b2b_ones_val", ser_data_val, 1'b1);
      chk1("b2b_ones_bit", ser_data, 1'b1);
      if (i == 15) begin
        chk1("b2b_last_busy", busy, 1'b0);
        data = 16'h0000; data_mod = 4'd0; data_val = 1'b1;
      end
      tick();
      data_val = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      chk1("b2b_zeros_val", ser_data_val, 1'b1);
      chk1("b2b_zeros_bit", ser_data, 1'b0);
      tick();
    end
    chk_idle("b2b_end");

    // Word offered while busy is ignored.
    data = 16'hC003; data_mod = 4'd0; data_val = 1'b1;
    tick();
    data_val = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk1("ign_val", ser_data_val, 1'b1);
      chk1("ign_bit", ser_data, word_bit(16'hC003, i));
      if (i == 3) begin
        chk1("ign_busy", busy, 1'b1);
        data = 16'h1234; data_mod = 4'd0; data_val = 1'b1;
      end else begin
        data_val = 1'b0;
      end
      tick();
    end
    chk_idle("ign_end");
    tick();
    chk_idle("ign_end2");

    // Asynchronous reset mid-word after 5 bits.
    data = 16'hFFFF; data_mod = 4'd0; data_val = 1'b1;
    tick();
    data_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk1("ar_pre_val", ser_data_val, 1'b1);
      tick();
    end
    #2;
    arst_n = 1'b0;
    #1;
    chk_idle("ar_async");
    tick();
    chk_idle("ar_hold");
    arst_n = 1'b1;
    tick();
    chk_idle("ar_release");
    tick();
    chk_idle("ar_release2");
    send_check("ar_next", 16'h9ABC, 4'd0, 16);

    // Loopback into a receiver that assembles 16-bit words.
    for (int k = 0; k < 4; k++) begin
      word = 16'($urandom);
      data = word; data_mod = 4'd0; data_val = 1'b1;
      tick();
      data_val = 1'b0;
      rx = '0; nbits = 0;
      for (int c = 0; c < 20; c++) begin
        if (ser_data_val) begin
          rx = {rx[14:0], ser_data};
          nbits++;
        end
        tick();
      end
      chk16("loop_word", rx, word);
      chk16("loop_nbits", 16'(nbits), 16'd16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic word_bit(input logic [15:0] w, input int i);
    return w[15-i];
  endfunction

endmodule
